// File: rtl/bram_read_checker.sv
// BRAM port-B read-back checker: after a warm-up window, compares each returned word against
// the A<<1 pattern the writer stores and tallies matches and mismatches until PASS_COUNT.
module bram_read_checker #(
   parameter int unsigned RD_LATENCY    = 1,
   parameter int unsigned WARMUP_CYCLES = 4096,
   parameter int unsigned PASS_COUNT    = 65536
) (
   input  logic        clk_100mhz,
   input  logic        reset,
   input  logic        locked,
   input  logic        rd_valid,
   input  logic [9:0]  rd_addr,
   input  logic [31:0] rd_data,
   output logic [1:0]  state,
   output logic        error,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [31:0] match_count,
   output logic [9:0]  first_err_addr,
   output logic [31:0] first_err_data
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StWarmup = 2'd1,
      StCheck  = 2'd2,
      StDone   = 2'd3
   } state_e;

   localparam logic [12:0] WarmLast   = 13'(WARMUP_CYCLES - 1);
   localparam logic [31:0] PassTarget = 32'(PASS_COUNT);

   state_e                st_q;
   logic [12:0]           warm_cnt_q;
   logic [RD_LATENCY-1:0] vld_pipe_q;
   logic [9:0]            addr_pipe_q [RD_LATENCY];
   logic                  cmp_vld_q;
   logic                  cmp_ok_q;
   logic [9:0]            cmp_addr_q;
   logic [31:0]           cmp_data_q;

   logic        flush;
   logic        issue;
   logic        count_en;
   logic [9:0]  data_addr;
   logic [31:0] match_inc;

   // Only reads issued while checking enter the pipe, so a read from the last warm-up cycle
   // is never compared even though its data returns during CHECK.
   always_comb begin
      flush     = (st_q == StIdle) || (!locked && (st_q == StWarmup || st_q == StCheck));
      issue     = rd_valid && (st_q == StCheck);
      count_en  = (st_q == StCheck) && locked && cmp_vld_q;
      data_addr = addr_pipe_q[RD_LATENCY-1];
      match_inc = (match_count == 32'hFFFF_FFFF) ? match_count : match_count + 32'd1;
   end

   always_ff @(posedge clk_100mhz) begin
      if (reset) begin
         vld_pipe_q <= '0;
         for (int i = 0; i < int'(RD_LATENCY); i++) addr_pipe_q[i] <= '0;
         cmp_vld_q  <= 1'b0;
         cmp_ok_q   <= 1'b0;
         cmp_addr_q <= '0;
         cmp_data_q <= '0;
      end else begin
         addr_pipe_q[0] <= rd_addr;
         for (int i = 1; i < int'(RD_LATENCY); i++) addr_pipe_q[i] <= addr_pipe_q[i-1];
         cmp_ok_q   <= (rd_data == {21'b0, data_addr, 1'b0});
         cmp_addr_q <= data_addr;
         cmp_data_q <= rd_data;
         if (flush) begin
            vld_pipe_q <= '0;
            cmp_vld_q  <= 1'b0;
         end else begin
            vld_pipe_q[0] <= issue;
            for (int i = 1; i < int'(RD_LATENCY); i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
            cmp_vld_q <= vld_pipe_q[RD_LATENCY-1];
         end
      end
   end

   always_ff @(posedge clk_100mhz) begin
      if (reset) begin
         st_q           <= StIdle;
         warm_cnt_q     <= '0;
         error          <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         match_count    <= '0;
         first_err_addr <= '0;
         first_err_data <= '0;
      end else begin
         if (count_en) begin
            if (cmp_ok_q) begin
               match_count <= match_inc;
            end else begin
               if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
               if (!error) begin
                  error          <= 1'b1;
                  first_err_addr <= cmp_addr_q;
                  first_err_data <= cmp_data_q;
               end
            end
         end
         case (st_q)
            StIdle: begin
               warm_cnt_q <= '0;
               if (locked) st_q <= StWarmup;
            end
            StWarmup: begin
               if (!locked) begin
                  st_q       <= StIdle;
                  warm_cnt_q <= '0;
               end else if (warm_cnt_q == WarmLast) begin
                  st_q       <= StCheck;
                  warm_cnt_q <= '0;
               end else begin
                  warm_cnt_q <= warm_cnt_q + 13'd1;
               end
            end
            StCheck: begin
               if (!locked) begin
                  st_q <= StIdle;
               end else if (count_en && cmp_ok_q && match_inc >= PassTarget) begin
                  st_q <= StDone;
                  pass <= !error;
               end
            end
            StDone: ;
            default: st_q <= StIdle;
         endcase
      end
   end

   assign state = st_q;

endmodule

// File: tb/tb_bram_read_checker.sv
// Bench for bram_read_checker: two instances (read latency 1 and 3) share one stimulus stream
// and are compared every cycle against a scoreboard model driven from the behavioural rules.
module tb_bram_read_checker;

   localparam int Warm = 16;
   localparam int Pass = 100;

   logic        clk = 1'b0;
   logic        reset, locked, rd_valid;
   logic [9:0]  rd_addr;
   logic [31:0] iss_data;
   logic [31:0] rd_data1 = '0, rd_data3 = '0;
   logic [31:0] bp3 [3] = '{default: '0};

   logic [1:0]  st1, st3;
   logic        er1, er3, ps1, ps3;
   logic [15:0] ec1, ec3;
   logic [31:0] mc1, mc3, fd1, fd3;
   logic [9:0]  fa1, fa3;

   int n_checks = 0;
   int n_errors = 0;

   // Stimulus controls
   logic       rd_en = 1'b0, rnd_mode = 1'b0, bad5 = 1'b0, bad6 = 1'b0, all_bad = 1'b0;
   logic [9:0] addr_ctr = '0;

   // Model state, index 0 = latency 1, index 1 = latency 3
   int          cyc = 0;
   int          m_state [2];
   int          m_check_at [2];
   logic        m_err [2], m_pass [2];
   logic [15:0] m_errc [2];
   logic [31:0] m_matc [2], m_fed [2];
   logic [9:0]  m_fea [2];
   logic        r_v [2][8];
   logic [9:0]  r_a [2][8];
   logic [31:0] r_d [2][8];

   always #5 clk = ~clk;

   bram_read_checker #(.RD_LATENCY(1), .WARMUP_CYCLES(Warm), .PASS_COUNT(Pass)) u_dut1 (
      .clk_100mhz(clk), .reset(reset), .locked(locked), .rd_valid(rd_valid),
      .rd_addr(rd_addr), .rd_data(rd_data1), .state(st1), .error(er1), .pass(ps1),
      .err_count(ec1), .match_count(mc1), .first_err_addr(fa1), .first_err_data(fd1)
   );

   bram_read_checker #(.RD_LATENCY(3), .WARMUP_CYCLES(Warm), .PASS_COUNT(Pass)) u_dut3 (
      .clk_100mhz(clk), .reset(reset), .locked(locked), .rd_valid(rd_valid),
      .rd_addr(rd_addr), .rd_data(rd_data3), .state(st3), .error(er3), .pass(ps3),
      .err_count(ec3), .match_count(mc3), .first_err_addr(fa3), .first_err_data(fd3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int clamp8(input int v);
      return (v < 0) ? 0 : ((v > 8) ? 8 : v);
   endfunction

   // A read issued in CHECK with lock held is scored lat+1 edges later if still checking.
   task automatic model_step(input int k, input int lat);
      int          due, slot;
      logic [31:0] exp_w;
      logic        done_now;
      due      = (cyc - lat - 1) & 7;
      slot     = cyc & 7;
      done_now = 1'b0;
      if (reset) begin
         m_state[k] = 0; m_err[k] = 1'b0; m_pass[k] = 1'b0; m_errc[k] = '0;
         m_matc[k] = '0; m_fea[k] = '0; m_fed[k] = '0;
         for (int i = 0; i < 8; i++) r_v[k][i] = 1'b0;
         return;
      end
      if (m_state[k] == 2 && locked && r_v[k][due]) begin
         exp_w = 32'(r_a[k][due]) * 32'd2;
         if (r_d[k][due] == exp_w) begin
            if (m_matc[k] != 32'hFFFF_FFFF) m_matc[k]++;
            done_now = (m_matc[k] >= Pass);
         end else begin
            if (m_errc[k] != 16'hFFFF) m_errc[k]++;
            if (!m_err[k]) begin
               m_err[k] = 1'b1; m_fea[k] = r_a[k][due]; m_fed[k] = r_d[k][due];
            end
         end
      end
      r_v[k][slot] = rd_valid && locked && (m_state[k] == 2);
      r_a[k][slot] = rd_addr;
      r_d[k][slot] = iss_data;
      case (m_state[k])
         0: if (locked) begin m_state[k] = 1; m_check_at[k] = cyc + Warm; end
         1: if (!locked) m_state[k] = 0; else if (cyc == m_check_at[k]) m_state[k] = 2;
         2: if (!locked) m_state[k] = 0;
            else if (done_now) begin m_state[k] = 3; m_pass[k] = !m_err[k]; end
         default: ;
      endcase
   endtask

   task automatic compare_inst(input string tag, input int k, input logic [1:0] s,
                               input logic e, input logic p, input logic [15:0] ec,
                               input logic [31:0] mc, input logic [9:0] fa,
                               input logic [31:0] fd);
      check({tag, ".state"}, 32'(s), 32'(m_state[k]));
      check({tag, ".error"}, 32'(e), 32'(m_err[k]));
      check({tag, ".pass"}, 32'(p), 32'(m_pass[k]));
      check({tag, ".err_count"}, 32'(ec), 32'(m_errc[k]));
      check({tag, ".match_count"}, mc, m_matc[k]);
      check({tag, ".first_err_addr"}, 32'(fa), 32'(m_fea[k]));
      check({tag, ".first_err_data"}, fd, m_fed[k]);
   endtask

   initial forever begin
      @(posedge clk);
      model_step(0, 1);
      model_step(1, 3);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (cyc > 0) begin
         compare_inst("dut1", 0, st1, er1, ps1, ec1, mc1, fa1, fd1);
         compare_inst("dut3", 1, st3, er3, ps3, ec3, mc3, fa3, fd3);
      end
   end

   // Ideal BRAM: data for the address sampled at the last edge, delayed by each read latency.
   task automatic tick();
      @(negedge clk);
      rd_data1 = iss_data;
      bp3[2] = bp3[1]; bp3[1] = bp3[0]; bp3[0] = iss_data;
      rd_data3 = bp3[2];
   endtask

   task automatic drive_next();
      logic [9:0] a;
      if (rnd_mode) begin
         rd_valid = ($urandom_range(0, 3) != 0);
         a = 10'($urandom_range(0, 1023));
      end else begin
         rd_valid = rd_en;
         a = addr_ctr;
         if (rd_en) addr_ctr = addr_ctr + 10'd1;
      end
      rd_addr  = a;
      iss_data = {21'b0, a, 1'b0};
      if ((bad5 && a == 10'd5) || (bad6 && a == 10'd6)) iss_data = 32'hDEAD_BEEF;
      if (all_bad) iss_data = ~iss_data;
      if (rnd_mode && $urandom_range(0, 7) == 0)
         iss_data = iss_data ^ (32'd1 << $urandom_range(0, 31));
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         drive_next();
      end
   endtask

   initial begin
      reset = 1'b1; locked = 1'b0; rd_valid = 1'b0; rd_addr = '0; iss_data = '0;
      cycles(3);
      check("reset_state", 32'(st1), 32'd0);
      check("reset_match", mc1, 32'd0);

      // Ideal run with a 3-cycle lock loss after 40 matches
      reset = 1'b0; locked = 1'b1; rd_en = 1'b1;
      cycles(1);
      check("p1_warmup", 32'(st1), 32'd1);
      for (int i = 0; i < 300 && mc1 != 32'd40; i++) cycles(1);
      check("p1_reach40", mc1, 32'd40);
      locked = 1'b0;
      cycles(1);
      check("p1_unlock_idle", 32'(st1), 32'd0);
      check("p1_unlock_hold", mc1, 32'd40);
      cycles(2);
      locked = 1'b1;
      cycles(1);
      check("p1_relock_warm", 32'(st1), 32'd1);
      cycles(15);
      check("p1_still_warm", 32'(st1), 32'd1);
      cycles(1);
      check("p1_check_again", 32'(st1), 32'd2);
      check("p1_check_hold", mc1, 32'd40);
      cycles(2);
      check("p1_resume_hold", mc1, 32'd40);
      cycles(1);
      check("p1_resume_41", mc1, 32'd41);
      for (int i = 0; i < 400 && !(st1 == 2'd3 && st3 == 2'd3); i++) cycles(1);
      check("p1_done1", 32'(st1), 32'd3);
      check("p1_done3", 32'(st3), 32'd3);
      check("p1_pass", 32'(ps1), 32'd1);
      check("p1_match", mc1, 32'd100);
      check("p1_errc", 32'(ec1), 32'd0);

      // Bad word at address 5
      reset = 1'b1; cycles(1);
      reset = 1'b0; rd_en = 1'b0; bad5 = 1'b1;
      cycles(17);
      check("p2_check", 32'(st1), 32'd2);
      addr_ctr = '0; rd_en = 1'b1; drive_next();
      for (int i = 0; i < 400 && !(st1 == 2'd3 && st3 == 2'd3); i++) cycles(1);
      check("p2_done", 32'(st1), 32'd3);
      check("p2_error", 32'(er1), 32'd1);
      check("p2_fea", 32'(fa1), 32'd5);
      check("p2_fed", fd1, 32'hDEAD_BEEF);
      check("p2_fea3", 32'(fa3), 32'd5);
      check("p2_pass", 32'(ps1), 32'd0);
      check("p2_errc", 32'(ec1), 32'd1);
      check("p2_match", mc1, 32'd100);

      // Reset mid-check with two errors recorded
      reset = 1'b1; cycles(1);
      reset = 1'b0; rd_en = 1'b0; bad6 = 1'b1;
      cycles(17);
      addr_ctr = '0; rd_en = 1'b1; drive_next();
      for (int i = 0; i < 300 && ec1 != 16'd2; i++) cycles(1);
      check("p3_errc2", 32'(ec1), 32'd2);
      reset = 1'b1; cycles(1);
      check("p3_rst_state", 32'(st1), 32'd0);
      check("p3_rst_error", 32'(er1), 32'd0);
      check("p3_rst_errc", 32'(ec1), 32'd0);
      check("p3_rst_match", mc1, 32'd0);
      check("p3_rst_fea", 32'(fa1), 32'd0);
      check("p3_rst_fed", fd1, 32'd0);

      // Address wrap 1020..3, exact update latency per instance
      reset = 1'b0; bad5 = 1'b0; bad6 = 1'b0; rd_en = 1'b0;
      cycles(22);
      check("p4_idle_match3", mc3, 32'd0);
      rd_en = 1'b1; addr_ctr = 10'd1020; drive_next();
      for (int k = 1; k <= 13; k++) begin
         tick();
         check($sformatf("p4_lat3_k%0d", k), mc3, 32'(clamp8(k - 4)));
         check($sformatf("p4_lat1_k%0d", k), mc1, 32'(clamp8(k - 2)));
         rd_en = (k < 8);
         drive_next();
      end
      check("p4_errc3", 32'(ec3), 32'd0);

      // Random traffic, corruption, lock drops and resets
      rnd_mode = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         tick();
         locked = ($urandom_range(0, 59) != 0);
         reset  = ($urandom_range(0, 399) == 0);
         drive_next();
      end

      // Error counter saturation
      rnd_mode = 1'b0; reset = 1'b1; locked = 1'b1; cycles(1);
      reset = 1'b0; all_bad = 1'b1; rd_en = 1'b1;
      cycles(17 + 65540);
      check("p6_errc_sat1", 32'(ec1), 32'h0000_FFFF);
      check("p6_errc_sat3", 32'(ec3), 32'h0000_FFFF);
      check("p6_match0", mc1, 32'd0);
      check("p6_state", 32'(st1), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bram_read_checker.md
BRAM_READ_CHECKER -- requirements
Module: bram_read_checker

Interface
REQ-001 Parameter RD_LATENCY, default 1; BRAM port-B read latency in cycles; legal range 1..3.
REQ-002 Parameter WARMUP_CYCLES, default 4096; cycles to wait after locked before checking; must exceed one full 30 MHz writer pass (1024 writes ≈ 3414 cycles at 100 MHz) plus the 50-cycle reader start delay.
REQ-003 Parameter PASS_COUNT, default 65536; number of matches needed to assert pass.
REQ-004 clk_100mhz  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 locked  input  1  clock-wizard lock indication, already synchronous to clk_100mhz.
REQ-007 rd_valid  input  1  a BRAM port-B read is issued this cycle (enb high).
REQ-008 rd_addr  input  10  port-B address issued this cycle.
REQ-009 rd_data  input  32  BRAM doutb.
REQ-010 state  output  2  0=IDLE, 1=WARMUP, 2=CHECK, 3=DONE.
REQ-011 error  output  1  sticky: at least one mismatch seen.
REQ-012 pass  output  1  PASS_COUNT matches reached with error=0.
REQ-013 err_count  output  16  mismatches; saturates at 16'hFFFF.
REQ-014 match_count  output  32  matches; saturates at 32'hFFFF_FFFF.
REQ-015 first_err_addr  output  10  address of the first mismatch.
REQ-016 first_err_data  output  32  data read at the first mismatch.

Function
REQ-017 Expected word for address A SHALL be {21'b0, A, 1'b0}, i.e. A<<1 zero-extended to 32 bits.
REQ-018 rd_valid and rd_addr SHALL be delayed through an RD_LATENCY-stage shift pipeline; rd_data SHALL be compared only in a cycle where the delayed valid is high.
REQ-019 The comparison result SHALL be registered; counters and flags SHALL update on the cycle after the data cycle. Total latency from address issue to counter update: RD_LATENCY+1 cycles.
REQ-020 IDLE: counters hold; pipeline flushed. Go to WARMUP when locked=1.
REQ-021 WARMUP: a 13-bit counter runs from 0. Go to CHECK when it reaches WARMUP_CYCLES-1. Reads seen during WARMUP are not checked.
REQ-022 CHECK: each compared read increments match_count or err_count (saturating).
REQ-023 CHECK → DONE when match_count reaches PASS_COUNT. Set pass=1 in the same update if error=0.
REQ-024 DONE: no further counting; outputs hold until reset.
REQ-025 On the first mismatch (error=0 → 1), capture first_err_addr and first_err_data. Later mismatches SHALL NOT overwrite them.
REQ-026 Errors do not stop checking. CHECK continues to PASS_COUNT; pass stays 0.
REQ-027 If locked falls in WARMUP or CHECK: next state is IDLE, pipeline valid bits and warm-up counter clear, counters and flags hold. Re-lock restarts WARMUP.
REQ-028 If locked falls in DONE: stay in DONE.
REQ-029 Address wrap 1023 → 0 needs no special handling. Expected value for address 1023 is 32'h0000_07FE.
REQ-030 A read issued in the last cycle of WARMUP SHALL NOT be checked, even if its data returns during CHECK. The pipeline valid is gated by state at issue.

Reset
REQ-031 reset=1 SHALL, on the next edge, clear:
- state to IDLE
- error, pass, err_count, match_count, first_err_addr, first_err_data to 0
- all pipeline stages and the warm-up counter to 0
REQ-032 reset SHALL take priority over locked and over any in-flight comparison.

Verification
REQ-033 locked=1, RD_LATENCY=1, WARMUP_CYCLES=16, PASS_COUNT=100, ideal BRAM model (data = addr<<1) → state reaches DONE, pass=1, match_count=100, err_count=0.
REQ-034 As REQ-033, but the model returns 32'hDEAD_BEEF for address 5 → error=1, first_err_addr=5, first_err_data=32'hDEAD_BEEF, pass=0, err_count=1, match_count=100 at DONE.
REQ-035 Addresses 1020..1023,0..3 with correct data, RD_LATENCY=3 → 8 matches, each counter update exactly 4 cycles after its address issue.
REQ-036 locked dropped for 3 cycles mid-CHECK after 40 matches → state IDLE then WARMUP; match_count stays 40; checking resumes only after 16 more cycles.
REQ-037 reset pulsed mid-CHECK with err_count=2 → next cycle all outputs are 0 and state=IDLE.
REQ-038 Force err_count to 16'hFFFE and inject 3 mismatches → err_count=16'hFFFF, no wrap.
